// File: rtl/uart_tx_frame_if.sv
// Push-side bus of the UART transmitter: byte writes in, FIFO status out.
`timescale 1ns/1ps
interface uart_tx_frame_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          tx_we_i;
    logic [7:0]    din_i;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;

    modport master (output tx_we_i, din_i,
                    input  full_o, empty_o, level_o, overflow_o);
    modport slave  (input  tx_we_i, din_i,
                    output full_o, empty_o, level_o, overflow_o);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: TX FIFO feeding a 5-8 bit / parity / 1-2 stop serialiser.
// All outputs are flops; next-state values are precomputed so done_o and
// tx_bit_o line up exactly with the bit they describe.
`timescale 1ns/1ps
module uart_tx_frame #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    input  logic                 tx_en_i,
    input  logic [1:0]           data_bits_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 stop2_i,
    uart_tx_frame_if.slave       fifo_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 tx_bit_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW:0]          wptr_q, rptr_q, level;
    logic                 full, empty, push, pop;
    logic [7:0]           head, used_mask;
    logic                 head_par;
    logic [DIV_WIDTH-1:0] nm1_in;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, nm1_q;
    logic [2:0]           idx_q, idx_d, dlast_q;
    logic [7:0]           sh_q, sh_d;
    logic                 par_en_q, par_q, stop2_q;
    logic                 tx_q, tx_d, done_q, done_d, busy_q, ovf_q;
    logic                 bit_end, start_ok;

    assign level = wptr_q - rptr_q;
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign push  = fifo_if.tx_we_i & ~full;
    assign head  = mem_q[rptr_q[AW-1:0]];

    // Parity covers only the bits the selected data length will send.
    assign used_mask = 8'hFF >> (2'd3 - data_bits_i);
    assign head_par  = ^(head & used_mask) ^ parity_odd_i;
    assign nm1_in    = (baud_div_i == '0) ? '0 : baud_div_i - DIV_WIDTH'(1);

    assign bit_end  = (cnt_q == nm1_q);
    assign start_ok = ~empty & tx_en_i;

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= fifo_if.din_i;
    end

    // Frame FSM next state, bit counters, pop decision and registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + DIV_WIDTH'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_ok) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: if (bit_end) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: if (bit_end) begin
                cnt_d = '0;
                sh_d  = sh_q >> 1;
                if (idx_q == dlast_q) begin
                    idx_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_PARITY: if (bit_end) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_STOP;
            end
            S_STOP: if (bit_end) begin
                cnt_d = '0;
                if (idx_q == {2'b00, stop2_q}) begin
                    idx_d = '0;
                    if (start_ok) begin
                        // Back-to-back: next START follows with no idle cycle.
                        pop     = 1'b1;
                        sh_d    = head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (cnt_d == nm1_q) && (idx_d == {2'b00, stop2_q});
    end

    // State, pointers, latched frame config and output flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            nm1_q    <= '0;
            dlast_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            if (pop) begin
                nm1_q    <= nm1_in;
                dlast_q  <= {1'b1, data_bits_i};
                par_en_q <= parity_en_i;
                par_q    <= head_par;
                stop2_q  <= stop2_i;
            end
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
            tx_q   <= tx_d;
            done_q <= done_d;
            busy_q <= (state_d != S_IDLE);
            ovf_q  <= fifo_if.tx_we_i & full;
        end
    end

    assign fifo_if.full_o     = full;
    assign fifo_if.empty_o    = empty;
    assign fifo_if.level_o    = level;
    assign fifo_if.overflow_o = ovf_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign tx_bit_o           = tx_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: line waveforms checked cycle by cycle
// against hand-computed bit sequences (bit i of a pattern = i-th line bit).
`timescale 1ns/1ps
module tb_uart_tx_frame;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic        tx_en = 1'b0;
    logic [1:0]  data_bits = 2'b11;
    logic        pen = 1'b0, podd = 1'b0, stop2 = 1'b0;
    logic        busy, done, tx;
    int          checks = 0, fails = 0;

    uart_tx_frame_if #(.FIFO_DEPTH(16)) ff ();

    uart_tx_frame #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .tx_en_i(tx_en),
        .data_bits_i(data_bits), .parity_en_i(pen), .parity_odd_i(podd),
        .stop2_i(stop2), .fifo_if(ff), .busy_o(busy), .done_o(done), .tx_bit_o(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        ff.tx_we_i = 1'b1;
        ff.din_i   = b;
        @(posedge clk);
        #1 ff.tx_we_i = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [15:0] bits, input int nb, input int n,
                         output int lat, output int lvl, output logic emp);
        int errs;
        bit seen;
        lat = 0; lvl = -1; emp = 1'bx; seen = 0; errs = 0;
        for (int w = 1; w <= 300 && !seen; w++) begin
            @(negedge clk);
            if (tx === 1'b0) begin seen = 1; lat = w; end
        end
        if (!seen) begin
            chk({tag, "_start_timeout"}, 32'd0, 32'd1);
            return;
        end
        lvl = int'(ff.level_o);
        emp = ff.empty_o;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < n; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (tx !== bits[i]) errs++;
                if (done !== ((i == nb-1) && (c == n-1))) errs++;
                if (busy !== 1'b1) errs++;
            end
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        int   lat, lvl, gaps, lerr, idle_err;
        logic emp;
        ff.tx_we_i = 1'b0;
        ff.din_i   = 8'h00;

        // Reset values while held in reset.
        #12;
        chk("rst_tx", tx, 1);
        chk("rst_empty", ff.empty_o, 1);
        chk("rst_level", ff.level_o, 0);
        chk("rst_full", ff.full_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ff.overflow_o, 0);
        @(negedge clk) rst_n = 1'b1;

        // 8N1, 0x55, N=4: first START is the second cycle after the push.
        baud_div = 16'd4; data_bits = 2'b11; pen = 0; stop2 = 0; tx_en = 1;
        push(8'h55);
        @(negedge clk);
        chk("8n1_level_vis", ff.level_o, 1);
        chk("8n1_idle_line", tx, 1);
        frame("8n1_bits", 16'h02AA, 10, 4, lat, lvl, emp);
        chk("8n1_latency", lat, 1);
        @(negedge clk);
        chk("8n1_busy_fall", busy, 0);
        chk("8n1_done_once", done, 0);

        // 7E2 then 7O2, 0x41, N=2.
        baud_div = 16'd2; data_bits = 2'b10; pen = 1; podd = 0; stop2 = 1;
        push(8'h41);
        frame("7e2_bits", 16'h0682, 11, 2, lat, lvl, emp);
        podd = 1;
        push(8'h41);
        frame("7o2_bits", 16'h0782, 11, 2, lat, lvl, emp);

        // 5O1, 0xFF, divisor 0 acts as 1; upper din bits ignored.
        baud_div = 16'd0; data_bits = 2'b00; pen = 1; podd = 1; stop2 = 0;
        push(8'hFF);
        frame("5o1_bits", 16'h00BE, 8, 1, lat, lvl, emp);
        @(negedge clk);

        // Burst: fill with transmitter disabled, overflow, then drain back-to-back.
        tx_en = 0; baud_div = 16'd1; data_bits = 2'b11; pen = 0; stop2 = 0;
        for (int j = 0; j < 16; j++) push((j % 2) ? 8'hF0 : 8'h0F);
        @(negedge clk);
        chk("burst_full", ff.full_o, 1);
        chk("burst_level16", ff.level_o, 16);
        push(8'hAA);
        @(negedge clk);
        chk("burst_ovf_pulse", ff.overflow_o, 1);
        chk("burst_level_hold", ff.level_o, 16);
        @(negedge clk);
        chk("burst_ovf_single", ff.overflow_o, 0);
        tx_en = 1;
        gaps = 0; lerr = 0;
        for (int j = 0; j < 16; j++) begin
            frame($sformatf("burst_frame%0d", j), (j % 2) ? 16'h03E0 : 16'h021E, 10, 1, lat, lvl, emp);
            if (lat != 1) gaps++;
            if (lvl != 15 - j) lerr++;
            if (j == 14) chk("burst_not_empty_early", emp, 0);
            if (j == 15) chk("burst_empty_last_pop", emp, 1);
        end
        chk("burst_no_gap", gaps, 0);
        chk("burst_levels", lerr, 0);
        @(negedge clk);
        chk("burst_idle_after", busy, 0);

        // Enable drop mid-DATA with 3 queued: frame completes, rest stay queued.
        tx_en = 0; baud_div = 16'd4;
        push(8'h55); push(8'h0F); push(8'hF0);
        @(negedge clk) tx_en = 1;
        fork
            frame("endrop_cur", 16'h02AA, 10, 4, lat, lvl, emp);
            begin repeat (16) @(negedge clk); tx_en = 0; end
        join
        idle_err = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_err++;
        end
        chk("endrop_idle", idle_err, 0);
        chk("endrop_level", ff.level_o, 2);
        tx_en = 1;
        frame("endrop_resume1", 16'h021E, 10, 4, lat, lvl, emp);
        chk("endrop_resume_lat", lat, 1);
        frame("endrop_resume2", 16'h03E0, 10, 4, lat, lvl, emp);
        chk("endrop_b2b", lat, 1);
        @(negedge clk);

        // Reset asserted during the parity bit of a 7E2 frame.
        tx_en = 0; baud_div = 16'd2; data_bits = 2'b10; pen = 1; podd = 0; stop2 = 1;
        push(8'h41); push(8'h22);
        @(negedge clk) tx_en = 1;
        @(negedge clk);
        chk("rstmid_start", tx, 0);
        repeat (16) @(negedge clk);
        chk("rstmid_parity", tx, 0);
        chk("rstmid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_tx_async", tx, 1);
        chk("rstmid_level_async", ff.level_o, 0);
        chk("rstmid_busy_async", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_idle", busy, 0);
        chk("rstmid_empty", ff.empty_o, 1);
        baud_div = 16'd4; data_bits = 2'b11; pen = 0; stop2 = 0;
        push(8'h55);
        frame("rstmid_fresh", 16'h02AA, 10, 4, lat, lvl, emp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
